systolic_writeback: RTL
=======================

Name: systolic_writeback

Overview:
- Drain engine for the 32x32 systolic matrix-multiply array.
- After a tile is accumulated, it sweeps the array's diagonal output selector and requantises each 69-bit accumulator to signed 32-bit.
- Writes results into ARRAY_SIZE per-row result SRAM banks, one column per bank per beat. This is the write side that mirrors the array's SRAM read side.

Parameters:
- ARRAY_SIZE, 32: array dimension, lane count and bank count.
- DATA_WIDTH, 32: width of each result element written to SRAM.
- ACC_WIDTH, 69: width of each array accumulator lane (2*DATA_WIDTH+5).
- ADDR_WIDTH, 10: result bank address width.

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- start  in  1  one-cycle request to drain one tile; accepted only in IDLE
- base_addr  in  ADDR_WIDTH  bank address of column 0; sampled on an accepted start
- shift_amt  in  6  arithmetic right-shift for requantisation; sampled on an accepted start
- matrix_index  out  6  diagonal selector driven to the array
- mul_outcome  in  ARRAY_SIZE*ACC_WIDTH  array output for the current matrix_index; lane i at [i*ACC_WIDTH +: ACC_WIDTH]
- sram_wen  out  1  write strobe, common to all banks
- sram_ready  in  1  bank arbiter accepts the write this cycle
- sram_waddr  out  ARRAY_SIZE*ADDR_WIDTH  per-bank address, lane i at [i*ADDR_WIDTH +: ADDR_WIDTH]
- sram_wdata  out  ARRAY_SIZE*DATA_WIDTH  per-bank data
- busy  out  1  high from start acceptance until done
- done  out  1  one-cycle pulse after the last write is accepted
- sat_flag  out  1  sticky; any lane saturated during the current tile

Behaviour:
- Reset values (immediate, async): state IDLE, matrix_index=0, sram_wen=0, sram_waddr=0, sram_wdata=0, busy=0, done=0, sat_flag=0, internal index counter idx=0.
- FSM states: IDLE, SWEEP, FLUSH, DONE.
- IDLE to SWEEP on start. In that cycle: latch base_addr and shift_amt, clear sat_flag, set busy=1, set idx=0.
- SWEEP: matrix_index=idx (combinational from idx). Each non-stalled cycle:
  - register the quantised mul_outcome into sram_wdata/sram_waddr and set sram_wen=1;
  - increment idx.
  - After capturing idx=ARRAY_SIZE-1, go to FLUSH.
- FLUSH: wait until the final write is accepted (sram_wen && sram_ready), then go to DONE with sram_wen=0.
- DONE: done=1 for one cycle, busy=0, return to IDLE.
- Stall: when sram_wen=1 and sram_ready=0, hold the output registers, idx, matrix_index and state. mul_outcome therefore stays stable, and no data is lost or duplicated.
- Column mapping: lane i at index idx holds element (row i, column j=(idx-i) mod ARRAY_SIZE). Per-lane address is base_addr+j, modulo 2^ADDR_WIDTH.
- Requantisation per lane:
  - signed arithmetic shift right by shift_amt;
  - saturate to [-2^(DATA_WIDTH-1), 2^(DATA_WIDTH-1)-1];
  - any clamp sets sat_flag.
- Latency: start at cycle T gives first sram_wen at T+2 and last wen at T+ARRAY_SIZE+1. With no stalls, done is at T+ARRAY_SIZE+2.
- start while busy is ignored; latched parameters are unchanged.
- The array must hold alu_start low during the sweep. This block does not check it.
- Reset mid-sweep aborts immediately: no done pulse, all outputs go to their reset values.

Optional Feature:
- Macro WB_ROUND_EN.
- Defined: round half away from zero before the shift. For shift_amt>0, add 2^(shift_amt-1) to non-negative values and 2^(shift_amt-1)-1 to negative values, in ACC_WIDTH+1 bits, then saturate.
- Undefined: pure truncation (floor).
- shift_amt=0 is identical in both builds.

Decomposition:
- Shared package systolic_pkg:
  - ARRAY_SIZE, DATA_WIDTH, ACC_WIDTH;
  - writeback state encoding;
  - lane slice helper constants.
- One sub-module, wb_quantize: a single-lane combinational shift/round/saturate with a sat output, instantiated ARRAY_SIZE times.

Test Plan:
- Identity tile: lane accumulators = 100*i + j, shift_amt=0, base_addr=0, sram_ready=1.
  - Required: bank i, address j holds 100*i + j for all i, j.
  - Required: done at T+34 and sat_flag=0.
- Back-pressure: sram_ready low for 5 cycles at the third write beat, and randomly 30% thereafter.
  - Required: exactly 32 accepted writes per bank, no duplicates.
  - Required: matrix_index frozen during each stall.
- Saturation: lane 3 = +2^40, lane 7 = -2^40, shift_amt=4.
  - Required: wdata 0x7FFFFFFF and 0x80000000 respectively, sat_flag=1.
  - Required: next start clears sat_flag.
- Rounding with shift_amt=1 on values 5, -5 and 4.
  - With WB_ROUND_EN: 3, -3, 2.
  - Without WB_ROUND_EN: 2, -3, 2.
- Wrap and ignore: base_addr=1020, then start asserted again mid-sweep.
  - Required: column 5 addresses 1 (wrap); second start ignored, one done only.
- Reset asserted at idx=10.
  - Required: sram_wen=0 and busy=0 immediately, no done.
  - Required: a fresh start then completes normally.

Source files
------------

// File: rtl/systolic_pkg.sv
// Shared constants and writeback state encoding for the 32x32 systolic array drain path.
package systolic_pkg;

    localparam int ARRAY_SIZE  = 32;
    localparam int DATA_WIDTH  = 32;
    localparam int ACC_WIDTH   = 2 * DATA_WIDTH + 5;
    localparam int ADDR_WIDTH  = 10;
    localparam int SHIFT_WIDTH = 6;
    localparam int INDEX_WIDTH = 6;
    localparam int IDX_WIDTH   = $clog2(ARRAY_SIZE);

    // One guard bit so the rounding bias can never overflow the accumulator range.
    localparam int EXT_WIDTH = ACC_WIDTH + 1;

    // Flattened per-lane bus widths; lane i lives at [i*W +: W].
    localparam int ACC_BUS_WIDTH  = ARRAY_SIZE * ACC_WIDTH;
    localparam int ADDR_BUS_WIDTH = ARRAY_SIZE * ADDR_WIDTH;
    localparam int DATA_BUS_WIDTH = ARRAY_SIZE * DATA_WIDTH;

    localparam logic [DATA_WIDTH-1:0] SAT_MAX = {1'b0, {(DATA_WIDTH-1){1'b1}}};
    localparam logic [DATA_WIDTH-1:0] SAT_MIN = {1'b1, {(DATA_WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {
        WB_IDLE,
        WB_SWEEP,
        WB_FLUSH,
        WB_DONE
    } wb_state_t;

endpackage

// File: rtl/wb_quantize.sv
// Single-lane requantiser: arithmetic right shift of a 69-bit accumulator, clamped to signed 32-bit.
// Build option WB_ROUND_EN: round half away from zero before the shift instead of truncating.
module wb_quantize
    import systolic_pkg::*;
(
    input  logic [ACC_WIDTH-1:0]   acc,
    input  logic [SHIFT_WIDTH-1:0] shift_amt,
    output logic [DATA_WIDTH-1:0]  q,
    output logic                   sat
);

    logic signed [EXT_WIDTH-1:0] ext;
    logic signed [EXT_WIDTH-1:0] shifted;
    logic                        pos_ovf;
    logic                        neg_ovf;
`ifdef WB_ROUND_EN
    logic signed [EXT_WIDTH-1:0] bias;
`endif

    // NOTE: every signal written here gets a value on every path; a missed branch would infer a latch.
    always_comb begin
        ext = {acc[ACC_WIDTH-1], acc};
`ifdef WB_ROUND_EN
        bias = '0;
        if (shift_amt != '0) begin
            bias = EXT_WIDTH'(1) << (shift_amt - SHIFT_WIDTH'(1));
            if (acc[ACC_WIDTH-1]) begin
                bias = bias - EXT_WIDTH'(1);
            end
        end
        ext = ext + bias;
`endif
        shifted = ext >>> shift_amt;

        // In range only when every bit above the result sign bit matches the true sign.
        pos_ovf = !shifted[EXT_WIDTH-1] && (shifted[EXT_WIDTH-2:DATA_WIDTH-1] != '0);
        neg_ovf =  shifted[EXT_WIDTH-1] && (shifted[EXT_WIDTH-2:DATA_WIDTH-1] != '1);
        sat     = pos_ovf || neg_ovf;

        if (pos_ovf) begin
            q = SAT_MAX;
        end else if (neg_ovf) begin
            q = SAT_MIN;
        end else begin
            q = shifted[DATA_WIDTH-1:0];
        end
    end

endmodule

// File: rtl/systolic_writeback.sv
// Drain engine: sweeps the array's diagonal selector, requantises every lane and writes one
// column per result bank per beat. Build option WB_ROUND_EN selects rounding in wb_quantize.
module systolic_writeback
    import systolic_pkg::*;
(
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic [ADDR_WIDTH-1:0]     base_addr,
    input  logic [SHIFT_WIDTH-1:0]    shift_amt,
    output logic [INDEX_WIDTH-1:0]    matrix_index,
    input  logic [ACC_BUS_WIDTH-1:0]  mul_outcome,
    output logic                      sram_wen,
    input  logic                      sram_ready,
    output logic [ADDR_BUS_WIDTH-1:0] sram_waddr,
    output logic [DATA_BUS_WIDTH-1:0] sram_wdata,
    output logic                      busy,
    output logic                      done,
    output logic                      sat_flag
);

    wb_state_t               state;
    wb_state_t               state_next;
    logic [IDX_WIDTH-1:0]    idx;
    logic [ADDR_WIDTH-1:0]   base_q;
    logic [SHIFT_WIDTH-1:0]  shift_q;

    logic                    stall;
    logic                    accept_start;
    logic                    capture;
    logic                    wen_clr;

    logic [ADDR_BUS_WIDTH-1:0] addr_next;
    logic [DATA_BUS_WIDTH-1:0] data_next;
    logic [ARRAY_SIZE-1:0]     lane_sat;

    // A pending write that the arbiter refuses freezes the whole pipeline, including the selector.
    assign stall        = sram_wen && !sram_ready;
    assign matrix_index = INDEX_WIDTH'(idx);

    // Lane i at selector idx carries column (idx - i) mod ARRAY_SIZE of row i.
    for (genvar i = 0; i < ARRAY_SIZE; i++) begin : g_lane
        logic [IDX_WIDTH-1:0] col;

        assign col = idx - IDX_WIDTH'(i);
        assign addr_next[i*ADDR_WIDTH +: ADDR_WIDTH] = base_q + ADDR_WIDTH'(col);

        wb_quantize u_quantize (
            .acc       (mul_outcome[i*ACC_WIDTH +: ACC_WIDTH]),
            .shift_amt (shift_q),
            .q         (data_next[i*DATA_WIDTH +: DATA_WIDTH]),
            .sat       (lane_sat[i])
        );
    end

    // NOTE: clocked state uses <= so every register samples pre-edge values regardless of block order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= WB_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next   = state;
        accept_start = 1'b0;
        capture      = 1'b0;
        wen_clr      = 1'b0;
        busy         = 1'b0;
        done         = 1'b0;

        case (state)
            WB_IDLE: begin
                if (start) begin
                    accept_start = 1'b1;
                    state_next   = WB_SWEEP;
                end
            end
            WB_SWEEP: begin
                busy = 1'b1;
                if (!stall) begin
                    capture = 1'b1;
                    if (idx == IDX_WIDTH'(ARRAY_SIZE - 1)) begin
                        state_next = WB_FLUSH;
                    end
                end
            end
            WB_FLUSH: begin
                busy = 1'b1;
                if (sram_wen && sram_ready) begin
                    wen_clr    = 1'b1;
                    state_next = WB_DONE;
                end
            end
            WB_DONE: begin
                done       = 1'b1;
                state_next = WB_IDLE;
            end
            default: begin
                state_next = WB_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx        <= '0;
            base_q     <= '0;
            shift_q    <= '0;
            sram_wen   <= 1'b0;
            sram_waddr <= '0;
            sram_wdata <= '0;
            sat_flag   <= 1'b0;
        end else begin
            if (accept_start) begin
                base_q   <= base_addr;
                shift_q  <= shift_amt;
                sat_flag <= 1'b0;
                idx      <= '0;
            end
            if (capture) begin
                sram_wen   <= 1'b1;
                sram_waddr <= addr_next;
                sram_wdata <= data_next;
                idx        <= idx + IDX_WIDTH'(1);
                if (|lane_sat) begin
                    sat_flag <= 1'b1;
                end
            end else if (wen_clr) begin
                sram_wen <= 1'b0;
            end
        end
    end

endmodule
